// File: rtl/link_frame_scheduler.sv
// link_frame_scheduler: sync/payload/flush bit sequencer for the 1200 b/s link.
// Define SATCOM_SCRAMBLE_EN to XOR payload bits with a x^7+x^6+1 PN sequence.
module link_frame_scheduler #(
  parameter int          DIV        = 83333,
  parameter int          FRAME_BITS = 10240,
  parameter logic [15:0] SYNC_WORD  = 16'hEB90,
  parameter int          SYNC_LEN   = 16,
  parameter int          LATENCY    = 1
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic        go,
  input  logic        src_bit,
  input  logic        rx_empty,
  input  logic        tx_full,
  output logic        src_rd,
  output logic        tx_bit,
  output logic        tx_valid,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic [2:0]  state,
  output logic [13:0] bit_cnt
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(DIV - 1);
  localparam logic [13:0] SYNC_LAST = 14'(SYNC_LEN - 1);
  localparam logic [13:0] PAY_LAST = 14'(FRAME_BITS - 1);
  localparam logic [13:0] FLUSH_N = 14'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    PAYLOAD = 3'd2,
    FLUSH   = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [13:0]     phase_q, phase_d;
  logic [13:0]     bit_cnt_q, bit_cnt_d;
  logic            underrun_q, underrun_d;
  logic            tx_valid_q, tx_bit_q, src_rd_q;
  logic            emit, pop, bit_d;
  logic            tick, slot;
  logic [3:0]      sidx;
  logic            pn_bit;

  assign tick = (tick_q == TMAX);
  assign slot = tick && !tx_full;
  assign sidx = 4'(SYNC_LEN - 1) - phase_q[3:0];

  // phase_q counts bits within the current state; bit_cnt_q spans the frame
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    underrun_d = underrun_q;
    emit       = 1'b0;
    pop        = 1'b0;
    bit_d      = 1'b0;
    if (state_q != IDLE)
      tick_d = tick ? '0 : tick_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d    = SYNC;
          tick_d     = '0;
          phase_d    = '0;
          bit_cnt_d  = '0;
          underrun_d = 1'b0;
        end
      end
      SYNC: begin
        if (slot) begin
          emit  = 1'b1;
          bit_d = SYNC_WORD[sidx];
          if (phase_q == SYNC_LAST) begin
            state_d = PAYLOAD;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 14'd1;
          end
        end
      end
      PAYLOAD: begin
        if (slot) begin
          if (rx_empty) begin
            underrun_d = 1'b1;
            state_d    = FLUSH;
            phase_d    = '0;
          end else begin
            emit  = 1'b1;
            pop   = 1'b1;
            bit_d = src_bit ^ pn_bit;
            if (phase_q == PAY_LAST) begin
              state_d = FLUSH;
              phase_d = '0;
            end else begin
              phase_d = phase_q + 14'd1;
            end
          end
        end
      end
      FLUSH: begin
        // leave one cycle after the last strobe so done never overlaps it
        if (phase_q == FLUSH_N) begin
          state_d = DONE;
        end else if (slot) begin
          emit    = 1'b1;
          phase_d = phase_q + 14'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (emit)
      bit_cnt_d = bit_cnt_q + 14'd1;
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      phase_q    <= '0;
      bit_cnt_q  <= '0;
      underrun_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_bit_q   <= 1'b0;
      src_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      underrun_q <= underrun_d;
      tx_valid_q <= emit;
      tx_bit_q   <= bit_d;
      src_rd_q   <= pop;
    end
  end

`ifdef SATCOM_SCRAMBLE_EN
  logic [6:0] lfsr_q, lfsr_d;

  assign pn_bit = lfsr_q[6];

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == IDLE && go)
      lfsr_d = 7'h7F;
    else if (pop)
      lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
  end

  always_ff @(posedge clk_100M) begin
    if (rst) lfsr_q <= 7'h7F;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign pn_bit = 1'b0;
`endif

  assign src_rd   = src_rd_q;
  assign tx_bit   = tx_bit_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign underrun = underrun_q;
  assign state    = state_q;
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: tb/tb_link_frame_scheduler.sv
// tb_link_frame_scheduler: random frames against a bit-stream model.
// Receive buffer is a queue; stalls are chosen per tick index.
module tb_link_frame_scheduler;

  localparam int          DIV = 4;
  localparam int          FB  = 8;
  localparam int          SL  = 4;
  localparam int          LAT = 3;
  localparam logic [15:0] SW  = 16'h000A;
`ifdef SATCOM_SCRAMBLE_EN
  localparam bit SCR = 1'b1;
`else
  localparam bit SCR = 1'b0;
`endif

  logic        clk_100M = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic        src_bit = 1'b0;
  logic        rx_empty = 1'b1;
  logic        tx_full = 1'b0;
  logic        src_rd, tx_bit, tx_valid, busy, done, underrun;
  logic [2:0]  state;
  logic [13:0] bit_cnt;

  link_frame_scheduler #(
    .DIV(DIV), .FRAME_BITS(FB), .SYNC_WORD(SW),
    .SYNC_LEN(SL), .LATENCY(LAT)
  ) dut (
    .clk_100M(clk_100M), .rst(rst), .go(go),
    .src_bit(src_bit), .rx_empty(rx_empty), .tx_full(tx_full),
    .src_rd(src_rd), .tx_bit(tx_bit), .tx_valid(tx_valid),
    .busy(busy), .done(done), .underrun(underrun),
    .state(state), .bit_cnt(bit_cnt)
  );

  always #5 clk_100M = ~clk_100M;

  int cyc = 0;
  always @(posedge clk_100M) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit rxq[$];
  bit obs_bits[$];
  int obs_cyc[$];
  int pops = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int busy_err = 0;
  bit chk_busy = 1'b0;
  int G = 0;
  int exp_done = 0;
  bit pn[FB];

  always @(negedge clk_100M) begin
    if (tx_valid) begin
      obs_bits.push_back(tx_bit);
      obs_cyc.push_back(cyc);
    end
    if (src_rd) begin
      pops++;
      if (rxq.size() > 0) void'(rxq.pop_front());
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (chk_busy && busy !== (cyc > G && cyc <= exp_done))
      busy_err++;
  end

  task automatic step();
    @(posedge clk_100M);
    #1;
    rx_empty = (rxq.size() == 0);
    src_bit  = rx_empty ? 1'($urandom % 2) : rxq[0];
  endtask

  task automatic run_frame(input int f);
    bit pay[$];
    bit stall[64];
    bit exp_bits[$];
    int exp_cyc[$];
    bit ur;
    int m, u, k, lastk, nu, off, terr;
    logic [31:0] gv, ev;
    for (int i = 0; i < 64; i++) stall[i] = 1'b0;
    if (f == 0) begin
      pay = '{1, 1, 0, 0, 0, 0, 1, 1};
    end else if (f == 2) begin
      for (int i = 0; i < 5; i++) pay.push_back(1'($urandom % 2));
    end else begin
      nu = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : FB;
      for (int i = 0; i < nu; i++) pay.push_back(1'($urandom % 2));
    end
    if (f == 1) begin
      stall[6] = 1'b1; stall[7] = 1'b1; stall[8] = 1'b1;
    end else if (f > 2) begin
      for (int i = 1; i < 40; i++) stall[i] = ($urandom_range(0, 4) == 0);
    end
    ur = (pay.size() < FB);
    m  = ur ? pay.size() : FB;
    for (int i = 0; i < SL; i++) exp_bits.push_back(SW[SL-1-i]);
    for (int i = 0; i < m; i++) exp_bits.push_back(pay[i] ^ (SCR & pn[i]));
    for (int i = 0; i < LAT - 1; i++) exp_bits.push_back(1'b0);
    rxq = pay;
    obs_bits.delete();
    obs_cyc.delete();
    pops = 0;
    done_cnt = 0;
    busy_err = 0;
    step();
    go = 1'b1;
    tx_full = 1'b0;
    G = cyc;
    nu = SL + m + (ur ? 1 : 0) + LAT - 1;
    u = 0; k = 0; lastk = 0;
    while (u < nu) begin
      k++;
      if (!stall[k]) begin
        if (!(ur && u == SL + m)) exp_cyc.push_back(G + k * DIV + 1);
        u++;
        lastk = k;
      end
    end
    exp_done = G + lastk * DIV + 2;
    chk_busy = 1'b1;
    for (int t = 0; t < exp_done - G + 20 && done_cnt == 0; t++) begin
      step();
      go = 1'b0;
      off = cyc - G;
      if (off % DIV == 0)
        tx_full = (off / DIV < 64) ? stall[off / DIV] : 1'b0;
      else
        tx_full = 1'($urandom % 2);
      if (f > 0 && off == 2 * DIV && ($urandom % 2) == 1) go = 1'b1;
    end
    tx_full = 1'b0;
    repeat (3) step();
    chk_busy = 1'b0;
    chk("done_seen", 32'(done_cnt > 0), 1);
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_cyc - G, exp_done - G);
    chk("strobes", obs_bits.size(), exp_bits.size());
    gv = '0; ev = '0;
    foreach (obs_bits[i]) gv = {gv[30:0], obs_bits[i]};
    foreach (exp_bits[i]) ev = {ev[30:0], exp_bits[i]};
    chk("stream", gv, ev);
    terr = 0;
    for (int i = 0; i < obs_cyc.size() && i < exp_cyc.size(); i++)
      if (obs_cyc[i] != exp_cyc[i]) terr++;
    chk("strobe_timing_errs", terr, 0);
    chk("pops", pops, m);
    chk("bit_cnt", bit_cnt, SL + m + LAT - 1);
    chk("underrun", underrun, ur);
    chk("busy_errs", busy_err, 0);
    chk("idle_after", state, 0);
  endtask

  task automatic rst_test();
    rxq.delete();
    for (int i = 0; i < FB; i++) rxq.push_back(1'($urandom % 2));
    step();
    go = 1'b1;
    tx_full = 1'b0;
    G = cyc;
    for (int t = 0; t < (SL + 3) * DIV + 2; t++) begin
      step();
      go = 1'b0;
    end
    chk("busy_mid", busy, 1);
    chk("state_mid", state, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk_100M);
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    obs_bits.delete();
    repeat (40) step();
    chk("post_rst_strobes", obs_bits.size(), 0);
    rst = 1'b1;
    go = 1'b1;
    step();
    rst = 1'b0;
    go = 1'b0;
    @(negedge clk_100M);
    chk("rst_over_go", state, 0);
  endtask

  initial begin
    for (int i = 0; i < FB; i++)
      pn[i] = (i < 7) ? 1'b1 : (pn[i-7] ^ pn[i-6]);
    repeat (3) step();
    @(negedge clk_100M);
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_bit", tx_bit, 0);
    chk("rst_src_rd", src_rd, 0);
    step();
    rst = 1'b0;
    repeat (2) step();
    for (int f = 0; f < 12; f++) run_frame(f);
    rst_test();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/link_frame_scheduler.md
# link_frame_scheduler

Frame-level controller for the 1200 b/s buffer-to-buffer link in the satcom telemetry path. On a `go` request it derives the bit tick from `clk_100M`, emits a sync word, then moves FRAME_BITS payload bits from the receive storage buffer to the transmit storage buffer one bit per tick. It then emits LATENCY-1 flush bits so the FEC/modem/AWGN pipeline drains, and reports completion or underrun. It is the sequencer that drives the receive-buffer read side and the transmit-buffer write side.

## Interface
Parameters:
- `DIV`, 83333, clk_100M cycles per bit tick (100 MHz / 1200).
- `FRAME_BITS`, 10240, payload bits per frame.
- `SYNC_WORD`, 16'hEB90, sync pattern; bits [SYNC_LEN-1:0] are sent MSB first.
- `SYNC_LEN`, 16, sync bits sent; legal range 1..16.
- `LATENCY`, 1, downstream pipeline depth; LATENCY-1 zero flush bits are sent.

Ports:
- `clk_100M` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `go` in 1: frame request; sampled only in IDLE.
- `src_bit` in 1: head bit of the receive buffer, first-word-fall-through.
- `rx_empty` in 1: receive buffer has no bits.
- `tx_full` in 1: transmit buffer cannot accept a bit.
- `src_rd` out 1: one-cycle pop strobe to the receive buffer.
- `tx_bit` out 1: bit to the transmit buffer.
- `tx_valid` out 1: one-cycle write strobe qualifying `tx_bit`.
- `busy` out 1: a frame is in progress.
- `done` out 1: one-cycle pulse when a frame ends.
- `underrun` out 1: sticky; the receive buffer ran dry mid-payload.
- `state` out 3: FSM state encoding.
- `bit_cnt` out 14: bits emitted in the current or last frame.

## Operation
- States: IDLE=0, SYNC=1, PAYLOAD=2, FLUSH=3, DONE=4. Encodings 5–7 are unreachable and return to IDLE.
- IDLE, on `go`=1:
  - go to SYNC;
  - clear `bit_cnt`, the tick counter and `underrun`;
  - reseed the scrambler LFSR, if present.
- Tick counter behaviour:
  - counts 0..DIV-1 only outside IDLE;
  - a tick occurs in the cycle where the count equals DIV-1, and the counter wraps to 0 on that cycle.
- Stall: if `tx_full`=1 at a tick in SYNC, PAYLOAD or FLUSH, nothing is emitted and nothing is popped. The same bit is retried on the next tick.
- SYNC, each unstalled tick:
  - emit the next sync bit;
  - after SYNC_LEN bits, go to PAYLOAD.
- PAYLOAD, each unstalled tick:
  - if `rx_empty`=1: set `underrun` and go to FLUSH; the remaining payload is abandoned;
  - else: sample `src_bit`, pulse `src_rd`, emit the bit;
  - after FRAME_BITS bits, go to FLUSH.
- FLUSH, each unstalled tick:
  - emit a 0;
  - after LATENCY-1 bits, go to DONE;
  - with LATENCY=1, go straight to DONE.
- DONE: lasts one cycle, then IDLE.
- `bit_cnt` increments once per emitted bit (sync, payload and flush). It holds its value in IDLE until the next `go`.
- `go` outside IDLE is ignored; it is not queued.

## Timing
- Reset values:
  - state=IDLE;
  - `src_rd`=0, `tx_valid`=0, `tx_bit`=0;
  - `busy`=0, `done`=0, `underrun`=0, `bit_cnt`=0;
  - tick counter=0;
  - LFSR=7'h7F.
- `rst` overrides `go` when both are high.
- Reset mid-frame returns the block to IDLE with no further strobes. Bits already popped are not restored.
- Bit strobes:
  - outputs are registered; for a tick in cycle T, `tx_valid`, `tx_bit` and `src_rd` are high in cycle T+1 for exactly one cycle;
  - `src_bit` is sampled in cycle T.
- Latency:
  - the first tick occurs DIV cycles after the `go` cycle;
  - an unstalled frame lasts (SYNC_LEN+FRAME_BITS+LATENCY-1)·DIV cycles to its last tick.
- `done` is high in the cycle after the last `tx_valid` pulse, i.e. while in DONE.
- `busy` is high from the cycle after `go` is accepted through the DONE cycle inclusive.
- The earliest next `go` is accepted in the cycle after DONE.

## Configuration
- `SATCOM_SCRAMBLE_EN` defined:
  - PAYLOAD bits are XORed with a 7-bit PN sequence x^7+x^6+1, seeded 7'h7F at `go`;
  - the LFSR advances only on emitted payload bits;
  - sync and flush bits are never scrambled.
- `SATCOM_SCRAMBLE_EN` undefined: payload bits pass through unchanged, and no LFSR logic exists.

## Test plan
- DIV=4, FRAME_BITS=8, SYNC_WORD=16'h000A, SYNC_LEN=4, LATENCY=1, scrambler off, receive buffer holding 8'hC3, `go` pulse:
  - `tx_bit` stream 1010_11000011, one strobe every 4 cycles;
  - 8 `src_rd` pulses;
  - `done` 1 cycle after the 12th strobe;
  - `bit_cnt`=12; `underrun`=0.
- Same setup with LATENCY=3: two trailing 0 bits; `bit_cnt`=14; `done` after the 14th strobe.
- `tx_full` held high for 3 ticks during PAYLOAD:
  - no strobes and no pops during those ticks;
  - frame completes 3 ticks later with identical data.
- `rx_empty` asserted after 5 payload bits: `underrun`=1; exactly 5 `src_rd` pulses; FLUSH and DONE still occur.
- `go` pulsed during SYNC is ignored; `rst` asserted during PAYLOAD: next cycle state=0, `busy`=0, and no `tx_valid` thereafter.
- With `SATCOM_SCRAMBLE_EN` and all-zero payload: payload output equals the LFSR sequence starting from seed 7'h7F, and sync bits are unchanged.
